// File: rtl/interpe_psum_accum_chn64.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | interpe_psum_accum_chn64: per-PE 64-lane psum FIFO read/accum/write-back |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module interpe_psum_accum_chn64 #(
  parameter int PIX_NUM  = 196,
  parameter int PASS_NUM = 4,
  parameter int DW       = 16,
  parameter int CHN      = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [CHN*DW-1:0]   new_psum_i,
  input  logic                new_psum_v_i,
  output logic                fifo_rd_en_o,
  input  logic [CHN*DW-1:0]   history_sum_i,
  input  logic                history_sum_v_i,
  output logic [CHN*DW-1:0]   fifo_wr_data_o,
  output logic                fifo_wr_en_o,
  output logic [CHN*DW-1:0]   out_sum_o,
  output logic                out_sum_v_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_underflow_o
);

  localparam int                 BW          = CHN * DW;
  localparam int                 PIX_W       = 12;
  localparam int                 PASS_W      = 8;
  localparam logic [PIX_W-1:0]   PIX_LAST    = PIX_W'(PIX_NUM - 1);
  localparam logic [PASS_W-1:0]  PASS_PENULT = PASS_W'((PASS_NUM > 1) ? (PASS_NUM - 2) : 0);
  localparam logic               MULTI_PASS  = (PASS_NUM > 1);
  localparam logic               TWO_PASS    = (PASS_NUM == 2);
  localparam logic [DW-1:0]      SAT_MAX     = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]      SAT_MIN     = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FIRST = 3'd1,
    S_ACCUM = 3'd2,
    S_LAST  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
  logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;

  logic                s1_v_q;
  logic                s1_out_q;
  logic                s1_last_q;
  logic [BW-1:0]       s1_data_q;

  logic                wr_en_q;
  logic [BW-1:0]       wr_data_q;
  logic                out_v_q;
  logic [BW-1:0]       out_sum_q;
  logic                done_q;
  logic                err_q;

  logic                w_active;
  logic                w_accept;
  logic                w_pix_wrap;
  logic                w_pop;
  logic                w_final_word;
  logic [BW-1:0]       w_hist;
  logic [BW-1:0]       w_result;

  assign w_active     = (state_q == S_FIRST) || (state_q == S_ACCUM) || (state_q == S_LAST);
  assign w_accept     = new_psum_v_i && w_active;
  assign w_pix_wrap   = (pix_cnt_q == PIX_LAST);
  // Single-pass tiles have nothing stored, so LAST only pops when history exists.
  assign w_pop        = w_accept && ((state_q == S_ACCUM) || ((state_q == S_LAST) && MULTI_PASS));
  assign w_final_word = w_accept && (state_q == S_LAST) && w_pix_wrap;
  assign w_hist       = history_sum_v_i ? history_sum_i : '0;

  for (genvar i = 0; i < CHN; i++) begin : g_lane
    logic signed [DW:0] w_sum;
    assign w_sum = $signed({s1_data_q[i*DW+DW-1], s1_data_q[i*DW +: DW]})
                 + $signed({w_hist[i*DW+DW-1], w_hist[i*DW +: DW]});
    assign w_result[i*DW +: DW] = (w_sum[DW] == w_sum[DW-1]) ? w_sum[DW-1:0]
                                : (w_sum[DW] ? SAT_MIN : SAT_MAX);
  end

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    pass_cnt_d = pass_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = MULTI_PASS ? S_FIRST : S_LAST;
          pix_cnt_d  = '0;
          pass_cnt_d = '0;
        end
      end
      S_FIRST, S_ACCUM, S_LAST: begin
        if (w_accept) begin
          if (w_pix_wrap) begin
            pix_cnt_d  = '0;
            pass_cnt_d = pass_cnt_q + 1'b1;
            if (state_q == S_FIRST) begin
              state_d = TWO_PASS ? S_LAST : S_ACCUM;
            end else if (state_q == S_ACCUM) begin
              if (pass_cnt_q == PASS_PENULT) state_d = S_LAST;
            end else begin
              state_d = S_DRAIN;
            end
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (done_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pix_cnt_q  <= '0;
      pass_cnt_q <= '0;
      s1_v_q     <= 1'b0;
      s1_out_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_data_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      out_v_q    <= 1'b0;
      out_sum_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      pass_cnt_q <= pass_cnt_d;

      s1_v_q    <= w_pop;
      s1_out_q  <= (state_q == S_LAST);
      s1_last_q <= w_final_word;
      if (w_pop) s1_data_q <= new_psum_i;

      wr_en_q <= 1'b0;
      out_v_q <= 1'b0;
      done_q  <= 1'b0;
      // Copy words (first pass / single pass) never collide with an accumulated
      // word leaving stage 1, because a copy pass never follows an add pass.
      if (s1_v_q) begin
        if (s1_out_q) begin
          out_v_q   <= 1'b1;
          out_sum_q <= w_result;
          done_q    <= s1_last_q;
        end else begin
          wr_en_q   <= 1'b1;
          wr_data_q <= w_result;
        end
      end else if (w_accept && !w_pop) begin
        if (state_q == S_LAST) begin
          out_v_q   <= 1'b1;
          out_sum_q <= new_psum_i;
          done_q    <= w_final_word;
        end else begin
          wr_en_q   <= 1'b1;
          wr_data_q <= new_psum_i;
        end
      end

      if (s1_v_q != history_sum_v_i) err_q <= 1'b1;
    end
  end

  assign fifo_rd_en_o    = w_pop;
  assign fifo_wr_en_o    = wr_en_q;
  assign fifo_wr_data_o  = wr_data_q;
  assign out_sum_o       = out_sum_q;
  assign out_sum_v_o     = out_v_q;
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = done_q;
  assign err_underflow_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_interpe_psum_accum_chn64.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_interpe_psum_accum_chn64: scoreboard bench, three tile configurations |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_interpe_psum_accum_chn64;

  localparam int DW  = 16;
  localparam int CHN = 64;
  localparam int BW  = DW * CHN;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  // Instance A: PIX_NUM=4, PASS_NUM=3
  logic start_a, nv_a, rd_a, hv_a, wr_a, ov_a, busy_a, done_a, err_a, withhold_a;
  logic [BW-1:0] np_a, hd_a, wd_a, os_a;
  // Instance B: PIX_NUM=1, PASS_NUM=2
  logic start_b, nv_b, rd_b, hv_b, wr_b, ov_b, busy_b, done_b, err_b;
  logic [BW-1:0] np_b, hd_b, wd_b, os_b;
  // Instance C: PIX_NUM=2, PASS_NUM=1
  logic start_c, nv_c, rd_c, hv_c, wr_c, ov_c, busy_c, done_c, err_c;
  logic [BW-1:0] np_c, hd_c, wd_c, os_c;

  interpe_psum_accum_chn64 #(.PIX_NUM(4), .PASS_NUM(3), .DW(DW), .CHN(CHN)) u_dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .new_psum_i(np_a), .new_psum_v_i(nv_a),
    .fifo_rd_en_o(rd_a), .history_sum_i(hd_a), .history_sum_v_i(hv_a),
    .fifo_wr_data_o(wd_a), .fifo_wr_en_o(wr_a), .out_sum_o(os_a), .out_sum_v_o(ov_a),
    .busy_o(busy_a), .done_o(done_a), .err_underflow_o(err_a));

  interpe_psum_accum_chn64 #(.PIX_NUM(1), .PASS_NUM(2), .DW(DW), .CHN(CHN)) u_dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .new_psum_i(np_b), .new_psum_v_i(nv_b),
    .fifo_rd_en_o(rd_b), .history_sum_i(hd_b), .history_sum_v_i(hv_b),
    .fifo_wr_data_o(wd_b), .fifo_wr_en_o(wr_b), .out_sum_o(os_b), .out_sum_v_o(ov_b),
    .busy_o(busy_b), .done_o(done_b), .err_underflow_o(err_b));

  interpe_psum_accum_chn64 #(.PIX_NUM(2), .PASS_NUM(1), .DW(DW), .CHN(CHN)) u_dut_c (
    .clk(clk), .rst(rst), .start_i(start_c), .new_psum_i(np_c), .new_psum_v_i(nv_c),
    .fifo_rd_en_o(rd_c), .history_sum_i(hd_c), .history_sum_v_i(hv_c),
    .fifo_wr_data_o(wd_c), .fifo_wr_en_o(wr_c), .out_sum_o(os_c), .out_sum_v_o(ov_c),
    .busy_o(busy_c), .done_o(done_c), .err_underflow_o(err_c));

  // External FIFO models: data returned one cycle after a pop, flushed by rst.
  logic [BW-1:0] fifo_a[$];
  logic [BW-1:0] fifo_b[$];

  always @(posedge clk) begin
    if (rst) begin
      fifo_a.delete();
      hv_a <= 1'b0;
      hd_a <= '0;
    end else begin
      hv_a <= 1'b0;
      if (rd_a && fifo_a.size() > 0) begin
        hd_a <= fifo_a.pop_front();
        hv_a <= !withhold_a;
      end
      if (wr_a) fifo_a.push_back(wd_a);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      fifo_b.delete();
      hv_b <= 1'b0;
      hd_b <= '0;
    end else begin
      hv_b <= 1'b0;
      if (rd_b && fifo_b.size() > 0) begin
        hd_b <= fifo_b.pop_front();
        hv_b <= 1'b1;
      end
      if (wr_b) fifo_b.push_back(wd_b);
    end
  end

  logic [BW-1:0] exp_wr_a[$];
  logic [BW-1:0] exp_out_a[$];
  int            hist_a[4][CHN];

  function automatic int lane_val(int pat, int p, int x, int l);
    if (pat == 0) return 1;
    return (p * 7 + x * 13 + l * 3) - 100;
  endfunction

  function automatic logic [BW-1:0] mk_word(int pat, int p, int x);
    logic [BW-1:0] w;
    for (int l = 0; l < CHN; l++) w[l*DW +: DW] = DW'(lane_val(pat, p, x, l));
    return w;
  endfunction

  function automatic int sat16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    start_a = 0; nv_a = 0; np_a = '0; withhold_a = 0;
    start_b = 0; nv_b = 0; np_b = '0;
    start_c = 0; nv_c = 0; np_c = '0; hv_c = 0; hd_c = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_a, wr_a, ov_a, busy_a, done_a, err_a} !== 6'b0 || wd_a !== '0 || os_a !== '0) begin
      errors++;
      $display("FAIL reset_a: got ctl=%b expected 000000", {rd_a, wr_a, ov_a, busy_a, done_a, err_a});
    end
    checks++;
    if ({rd_b, wr_b, ov_b, busy_b, done_b, err_b} !== 6'b0 || wd_b !== '0 || os_b !== '0) begin
      errors++;
      $display("FAIL reset_b: got ctl=%b expected 000000", {rd_b, wr_b, ov_b, busy_b, done_b, err_b});
    end
    checks++;
    if ({rd_c, wr_c, ov_c, busy_c, done_c, err_c} !== 6'b0 || wd_c !== '0 || os_c !== '0) begin
      errors++;
      $display("FAIL reset_c: got ctl=%b expected 000000", {rd_c, wr_c, ov_c, busy_c, done_c, err_c});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Runs one 12-word tile on instance A with optional gaps, a spurious start,
  // a withheld history return, or a reset injected before word abort_w.
  task automatic run_tile_a(input int pat, input int gap, input bit mid_start,
                            input int withhold_w, input int abort_w, input bit exp_err);
    int w, cyc, p, x, hv;
    bit done_seen, exp_rd;
    logic [BW-1:0] word, res, expw;
    w = 0; cyc = 0; p = 0; done_seen = 0;
    exp_wr_a.delete();
    exp_out_a.delete();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b expected 1", busy_a);
    end
    while (!done_seen && cyc < 300) begin
      nv_a = 1'b0; withhold_a = 1'b0; exp_rd = 1'b0;
      start_a = mid_start && (cyc == 6);
      if (w < 12 && (cyc % (gap + 1)) == 0) begin
        if (w == abort_w) begin
          rst = 1'b1;
          @(negedge clk);
          checks++;
          if ({rd_a, wr_a, ov_a, busy_a, done_a, err_a} !== 6'b0 || wd_a !== '0 || os_a !== '0) begin
            errors++;
            $display("FAIL reset_mid_tile: got ctl=%b expected 000000", {rd_a, wr_a, ov_a, busy_a, done_a, err_a});
          end
          rst = 1'b0;
          exp_wr_a.delete();
          exp_out_a.delete();
          @(negedge clk);
          return;
        end
        p = w / 4; x = w % 4;
        word = mk_word(pat, p, x);
        nv_a = 1'b1; np_a = word;
        withhold_a = (w == withhold_w);
        exp_rd = (p > 0);
        for (int l = 0; l < CHN; l++) begin
          hv = (p == 0 || w == withhold_w) ? 0 : hist_a[x][l];
          hist_a[x][l] = sat16(hv + lane_val(pat, p, x, l));
          res[l*DW +: DW] = DW'(hist_a[x][l]);
        end
        if (p == 2) exp_out_a.push_back(res);
        else exp_wr_a.push_back(res);
        w++;
      end
      #1;
      checks++;
      if (rd_a !== exp_rd) begin
        errors++;
        $display("FAIL fifo_rd_en word %0d: got %b expected %b", w, rd_a, exp_rd);
      end
      @(negedge clk);
      cyc++;
      if (wr_a) begin
        checks++;
        if (exp_wr_a.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wr: got fifo_wr_en=1 expected 0 (cycle %0d)", cyc);
        end else begin
          expw = exp_wr_a.pop_front();
          if (wd_a !== expw) begin
            errors++;
            $display("FAIL wr_data: got %h expected %h (low 128b)", wd_a[127:0], expw[127:0]);
          end
        end
      end
      if (ov_a) begin
        checks++;
        if (exp_out_a.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got out_sum_v=1 expected 0 (cycle %0d)", cyc);
        end else begin
          expw = exp_out_a.pop_front();
          if (os_a !== expw) begin
            errors++;
            $display("FAIL out_sum: got %h expected %h (low 128b)", os_a[127:0], expw[127:0]);
          end
        end
      end
      if (done_a) begin
        done_seen = 1'b1;
        checks++;
        if (!(ov_a === 1'b1 && exp_out_a.size() == 0 && w == 12)) begin
          errors++;
          $display("FAIL done_timing: got done with out_v=%b pending=%0d words=%0d expected 1/0/12",
                   ov_a, exp_out_a.size(), w);
        end
      end
    end
    nv_a = 1'b0; start_a = 1'b0; withhold_a = 1'b0;
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL done_timeout: got no done expected done within 300 cycles");
    end
    checks++;
    if (exp_wr_a.size() != 0 || exp_out_a.size() != 0) begin
      errors++;
      $display("FAIL missing_results: got %0d/%0d pending expected 0/0", exp_wr_a.size(), exp_out_a.size());
    end
    checks++;
    if (err_a !== exp_err) begin
      errors++;
      $display("FAIL err_underflow: got %b expected %b", err_a, exp_err);
    end
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || err_a !== exp_err) begin
      errors++;
      $display("FAIL after_done: got busy=%b done=%b err=%b expected 0 0 %b", busy_a, done_a, err_a, exp_err);
    end
  endtask

  task automatic test_back_to_back();
    run_tile_a(0, 0, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_gapped_with_restart();
    run_tile_a(0, 2, 1'b1, -1, -1, 1'b0);
  endtask

  task automatic test_varied_data();
    run_tile_a(1, 0, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_underflow();
    run_tile_a(1, 0, 1'b0, 5, -1, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (err_a !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b expected 1", err_a);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (err_a !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared_by_rst: got %b expected 0", err_a);
    end
  endtask

  task automatic test_reset_mid_tile();
    run_tile_a(1, 0, 1'b0, -1, 6, 1'b0);
    run_tile_a(1, 1, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_saturation();
    logic [BW-1:0] w0, w1, ex;
    for (int l = 0; l < CHN; l++) begin
      w0[l*DW +: DW] = DW'(-l);
      w1[l*DW +: DW] = DW'(3);
      ex[l*DW +: DW] = DW'(3 - l);
    end
    w0[15:0] = 16'sd30000;  w1[15:0] = 16'sd5000;   ex[15:0] = 16'h7FFF;
    w0[31:16] = -16'sd30000; w1[31:16] = -16'sd5000; ex[31:16] = 16'h8000;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    nv_b = 1'b1; np_b = w0;
    #1;
    checks++;
    if (rd_b !== 1'b0) begin
      errors++;
      $display("FAIL sat_first_rd: got %b expected 0", rd_b);
    end
    @(negedge clk);
    nv_b = 1'b0;
    checks++;
    if (wr_b !== 1'b1 || wd_b !== w0) begin
      errors++;
      $display("FAIL sat_first_wr: got en=%b %h expected 1 %h", wr_b, wd_b[127:0], w0[127:0]);
    end
    @(negedge clk);
    nv_b = 1'b1; np_b = w1;
    #1;
    checks++;
    if (rd_b !== 1'b1) begin
      errors++;
      $display("FAIL sat_last_rd: got %b expected 1", rd_b);
    end
    @(negedge clk);
    nv_b = 1'b0;
    checks++;
    if (ov_b !== 1'b0 || wr_b !== 1'b0) begin
      errors++;
      $display("FAIL sat_latency: got out_v=%b wr=%b expected 0 0", ov_b, wr_b);
    end
    @(negedge clk);
    checks++;
    if (ov_b !== 1'b1 || os_b !== ex || done_b !== 1'b1 || err_b !== 1'b0) begin
      errors++;
      $display("FAIL sat_out: got v=%b done=%b err=%b %h expected 1 1 0 %h",
               ov_b, done_b, err_b, os_b[127:0], ex[127:0]);
    end
    @(negedge clk);
    checks++;
    if (busy_b !== 1'b0) begin
      errors++;
      $display("FAIL sat_busy: got %b expected 0", busy_b);
    end
  endtask

  task automatic test_single_pass();
    logic [BW-1:0] w0, w1;
    for (int l = 0; l < CHN; l++) begin
      w0[l*DW +: DW] = 16'h0005;
      w1[l*DW +: DW] = DW'(l - 20);
    end
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    nv_c = 1'b1; np_c = w0;
    #1;
    checks++;
    if (rd_c !== 1'b0) begin
      errors++;
      $display("FAIL single_rd0: got %b expected 0", rd_c);
    end
    @(negedge clk);
    np_c = w1;
    checks++;
    if (ov_c !== 1'b1 || os_c !== w0 || wr_c !== 1'b0 || done_c !== 1'b0 || rd_c !== 1'b0) begin
      errors++;
      $display("FAIL single_out0: got v=%b wr=%b done=%b rd=%b %h expected 1 0 0 0 %h",
               ov_c, wr_c, done_c, rd_c, os_c[127:0], w0[127:0]);
    end
    @(negedge clk);
    nv_c = 1'b0;
    checks++;
    if (ov_c !== 1'b1 || os_c !== w1 || wr_c !== 1'b0 || done_c !== 1'b1) begin
      errors++;
      $display("FAIL single_out1: got v=%b wr=%b done=%b %h expected 1 0 1 %h",
               ov_c, wr_c, done_c, os_c[127:0], w1[127:0]);
    end
    @(negedge clk);
    checks++;
    if (busy_c !== 1'b0 || err_c !== 1'b0 || ov_c !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got busy=%b err=%b v=%b expected 0 0 0", busy_c, err_c, ov_c);
    end
    hv_c = 1'b1;
    @(negedge clk);
    hv_c = 1'b0;
    checks++;
    if (err_c !== 1'b1) begin
      errors++;
      $display("FAIL spurious_history: got err=%b expected 1", err_c);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped_with_restart();
    test_varied_data();
    test_underflow();
    test_reset_mid_tile();
    test_saturation();
    test_single_pass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
